// File: rtl/mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : mul_div_unit
// Purpose  : Iterative 32-cycle multiply/divide unit owning the HI/LO registers.
// Revision : 1.0 - initial release
// ============================================================================
module mul_div_unit #(
  parameter int ITER = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  mdop,
  input  logic [31:0] input1,
  input  logic [31:0] input2,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int c_CNT_W = $clog2(ITER + 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t             r_state;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_is_div;
  logic               r_neg_lo;
  logic               r_neg_hi;
  logic               r_dz;
  logic [31:0]        r_b;
  logic [63:0]        r_acc;

  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [32:0] w_madd;
  logic [63:0] w_mul_next;
  logic [32:0] w_rs;
  logic [32:0] w_diff;
  logic        w_qbit;
  logic [63:0] w_div_next;
  logic [63:0] w_step;
  logic [63:0] w_prod;
  logic [31:0] w_q;
  logic [31:0] w_r;
  logic [31:0] w_lo_div;
  logic [31:0] w_hi_div;

  // Signed ops (MULT/DIV) have mdop[0]=0; work on magnitudes, fix sign at the end.
  assign w_a_neg = ~mdop[0] & input1[31];
  assign w_b_neg = ~mdop[0] & input2[31];
  assign w_a_mag = w_a_neg ? (32'd0 - input1) : input1;
  assign w_b_mag = w_b_neg ? (32'd0 - input2) : input2;

  assign w_madd     = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_b} : 33'd0);
  assign w_mul_next = {w_madd, r_acc[31:1]};

  // Partial remainder lives in r_acc[63:32], dividend/quotient bits in r_acc[31:0].
  assign w_rs       = {r_acc[63:32], r_acc[31]};
  assign w_diff     = w_rs - {1'b0, r_b};
  assign w_qbit     = ~w_diff[32];
  assign w_div_next = {(w_qbit ? w_diff[31:0] : w_rs[31:0]), r_acc[30:0], w_qbit};

  assign w_step   = r_is_div ? w_div_next : w_mul_next;
  assign w_prod   = r_neg_lo ? (64'd0 - w_step) : w_step;
  assign w_q      = w_step[31:0];
  assign w_r      = w_step[63:32];
  assign w_lo_div = r_dz ? 32'hFFFF_FFFF : (r_neg_lo ? (32'd0 - w_q) : w_q);
  assign w_hi_div = r_neg_hi ? (32'd0 - w_r) : w_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_neg_lo <= 1'b0;
      r_neg_hi <= 1'b0;
      r_dz     <= 1'b0;
      r_b      <= '0;
      r_acc    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start && !flush) begin
            case (mdop)
              3'b000, 3'b001, 3'b010, 3'b011: begin
                r_is_div <= mdop[1];
                r_neg_lo <= w_a_neg ^ w_b_neg;
                r_neg_hi <= w_a_neg;
                r_dz     <= (input2 == 32'd0);
                r_b      <= mdop[1] ? w_b_mag : w_a_mag;
                r_acc    <= {32'd0, (mdop[1] ? w_a_mag : w_b_mag)};
                r_cnt    <= c_CNT_W'(ITER);
                r_state  <= S_RUN;
                busy     <= 1'b1;
              end
              3'b100:  hi <= input1;
              3'b101:  lo <= input1;
              default: ;
            endcase
          end
        end
        S_RUN: begin
          if (flush) begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
          end else begin
            r_acc <= w_step;
            r_cnt <= r_cnt - c_CNT_W'(1);
            if (r_cnt == c_CNT_W'(1)) begin
              if (r_is_div) begin
                hi <= w_hi_div;
                lo <= w_lo_div;
              end else begin
                hi <= w_prod[63:32];
                lo <= w_prod[31:0];
              end
              done    <= 1'b1;
              busy    <= 1'b0;
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mul_div_unit
// Purpose  : Directed self-checking bench for mul_div_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  mdop;
  logic [31:0] input1;
  logic [31:0] input2;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;
  int k;
  int k2;
  int dones;
  bit stable;

  always #5 clk = ~clk;

  mul_div_unit #(.ITER(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .mdop   (mdop),
    .input1 (input1),
    .input2 (input2),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the sampling edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    start  = 1'b1;
    mdop   = op;
    input1 = a;
    input2 = b;
    @(negedge clk);
    start  = 1'b0;
  endtask

  task automatic wait_done(output int cyc, output bit stab);
    logic [31:0] ph;
    logic [31:0] pl;
    ph   = hi;
    pl   = lo;
    cyc  = 0;
    stab = 1'b1;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (!done && (hi !== ph || lo !== pl)) stab = 1'b0;
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int  cyc;
    bit  stab;
    issue(op, a, b);
    chk({tag, "_busy_start"}, 64'(busy), 64'd1);
    wait_done(cyc, stab);
    chk({tag, "_latency"}, 64'(cyc), 64'd32);
    chk({tag, "_hi"}, 64'(hi), 64'(exp_hi));
    chk({tag, "_lo"}, 64'(lo), 64'(exp_lo));
    chk({tag, "_busy_end"}, 64'(busy), 64'd0);
    chk({tag, "_no_partial"}, 64'(stab), 64'd1);
    @(negedge clk);
    chk({tag, "_done_once"}, 64'(done), 64'd0);
  endtask

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    flush  = 1'b0;
    mdop   = 3'b111;
    input1 = '0;
    input2 = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset_hi",   64'(hi),   64'd0);
    chk("reset_lo",   64'(lo),   64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);

    run_op("multu_max", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("mult_neg",  3'b000, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB);

    issue(3'b100, 32'h1234_5678, 32'd0);
    chk("mthi_hi",   64'(hi),   64'h1234_5678);
    chk("mthi_lo",   64'(lo),   64'hFFFF_FFEB);
    chk("mthi_busy", 64'(busy), 64'd0);
    chk("mthi_done", 64'(done), 64'd0);

    issue(3'b110, 32'hDEAD_BEEF, 32'd0);
    chk("nop_hi", 64'(hi), 64'h1234_5678);
    chk("nop_busy", 64'(busy), 64'd0);

    run_op("div_neg",    3'b010, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu_zero",  3'b011, 32'd100,       32'd0,         32'h0000_0064, 32'hFFFF_FFFF);
    run_op("div_zero",   3'b010, 32'hFFFF_FF9C, 32'd0,         32'hFFFF_FF9C, 32'hFFFF_FFFF);
    run_op("div_ovf",    3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
    run_op("div_mixed",  3'b010, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);

    // Second start and operand changes while busy must be ignored.
    issue(3'b011, 32'd1000, 32'd3);
    repeat (4) @(negedge clk);
    issue(3'b001, 32'd5, 32'd5);
    chk("busy_ignore_busy", 64'(busy), 64'd1);
    wait_done(k2, stable);
    chk("busy_ignore_latency", 64'(5 + k2), 64'd32);
    chk("busy_ignore_lo", 64'(lo), 64'd333);
    chk("busy_ignore_hi", 64'(hi), 64'd1);
    chk("busy_ignore_stable", 64'(stable), 64'd1);
    @(negedge clk);
    chk("busy_ignore_done_once", 64'(done), 64'd0);
    repeat (3) @(negedge clk);
    chk("busy_ignore_no_restart", 64'(busy), 64'd0);

    // Flush mid-run leaves HI/LO untouched and produces no done.
    issue(3'b100, 32'hA5A5_A5A5, 32'd0);
    issue(3'b101, 32'hA5A5_A5A5, 32'd0);
    issue(3'b000, 32'd3, 32'd4);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", 64'(busy), 64'd0);
    chk("flush_hi",   64'(hi),   64'hA5A5_A5A5);
    chk("flush_lo",   64'(lo),   64'hA5A5_A5A5);
    chk("flush_done", 64'(done), 64'd0);
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("flush_no_late_done", 64'(dones), 64'd0);
    chk("flush_hi_late", 64'(hi), 64'hA5A5_A5A5);

    // Flush in IDLE suppresses a same-cycle start.
    flush = 1'b1;
    issue(3'b101, 32'h0000_0000, 32'd0);
    flush = 1'b0;
    chk("idle_flush_lo", 64'(lo), 64'hA5A5_A5A5);
    flush = 1'b1;
    issue(3'b001, 32'd2, 32'd2);
    flush = 1'b0;
    chk("idle_flush_busy", 64'(busy), 64'd0);

    // Reset in the middle of a divide.
    issue(3'b010, 32'd1000, 32'd7);
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_hi",   64'(hi),   64'd0);
    chk("midrst_lo",   64'(lo),   64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    run_op("post_rst_multu", 3'b001, 32'd6, 32'd7, 32'd0, 32'd42);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative multiply/divide unit in the EX stage, beside the ALU.
- Shares the ALU's operand buses (input1 = rs value, input2 = rt value).
- Owns the architectural HI/LO registers.
- Drives a busy stall to the hazard unit while a 32-cycle MULT/MULTU/DIV/DIVU runs.
- MFHI/MFLO results are muxed with the ALU out into the EX/MEM register by the EX stage.

Parameters:
- ITER, 32, iteration count for mul/div (equals operand width; fixed at 32 for this design)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- start  in  1  one-cycle request from EX; sampled only when busy=0
- mdop  in  3  operation select: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x no-op
- input1  in  32  operand A (rs), dividend / multiplicand / MTxx source
- input2  in  32  operand B (rt), divisor / multiplier
- flush  in  1  abort the in-flight operation (exception or branch squash)
- busy  out  1  high while an iterative op is in flight; pipeline stalls on any MFHI/MFLO/new mdop while high
- done  out  1  one-cycle pulse on the cycle HI/LO take a mul/div result
- hi  out  32  HI register
- lo  out  32  LO register

Behaviour:
- Reset (rst=1 at posedge) has priority over everything.
  - hi=0, lo=0, busy=0, done=0.
  - State returns to IDLE; an in-flight op is discarded.
- States: IDLE, RUN.
- IDLE, start=1 with mdop 000–011:
  - Latch operand magnitudes, sign flags and op.
  - Counter = ITER; go to RUN; busy=1 from the next cycle.
- IDLE, start=1 with MTHI/MTLO:
  - hi (or lo) <= input1 at that edge; stay in IDLE.
  - busy stays 0; done stays 0.
- IDLE, start=1 with mdop 11x: ignored.
- RUN:
  - One shift-add (multiply) or restoring shift-subtract (divide) step per cycle; counter decrements.
  - When counter reaches 0: apply sign correction, write hi/lo, done=1 for one cycle, busy=0, return to IDLE.
- Latency: start at edge N -> busy high N+1..N+32; hi/lo updated and done=1 at edge N+32. Fixed regardless of operands.
- start while busy=1: ignored; the op in flight is unaffected.
- flush=1:
  - In RUN: return to IDLE next edge; busy=0; hi/lo keep their pre-op values; no done.
  - In IDLE: suppresses a same-cycle start.
- MULT/MULTU: {hi,lo} = 64-bit product (signed or unsigned).
- DIV: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
- DIVU: unsigned quotient and remainder.
- Divide by zero (DIV or DIVU): lo = 32'hFFFF_FFFF, hi = input1 unchanged. Still takes 32 cycles.
- DIV 32'h8000_0000 / 32'hFFFF_FFFF: lo = 32'h8000_0000, hi = 0.
- hi/lo are stable outputs at all times except at the documented write edges; no partial results are ever visible.
- Operands are captured at start; changes to input1/input2 during RUN have no effect.

Test Plan:
- MULTU 32'hFFFF_FFFF × 32'hFFFF_FFFF -> busy for 32 cycles, then hi=32'hFFFF_FFFE, lo=32'h0000_0001, done pulses once.
- MULT -3 × 7 -> hi=32'hFFFF_FFFF, lo=32'hFFFF_FFEB. Then MTHI 32'h1234_5678 -> hi=32'h1234_5678 next edge, busy stays 0.
- DIV -7 / 2 -> lo=32'hFFFF_FFFD, hi=32'hFFFF_FFFF. DIVU 100 / 0 -> lo=32'hFFFF_FFFF, hi=32'h0000_0064 after 32 cycles.
- DIVU 1000/3 started; second start (MULTU 5×5) at cycle 5 -> ignored. Result lo=333, hi=1; done only at cycle 32.
- Preload hi=lo=32'hA5A5_A5A5 via MTHI/MTLO, start MULT, flush at cycle 10 -> busy=0 next cycle, hi/lo still 32'hA5A5_A5A5, no done.
- rst=1 at cycle 20 of a DIV -> next edge hi=lo=0, busy=0, done=0. A new MULTU 6×7 afterwards gives lo=42, hi=0.
